// File: rtl/storage_arbiter.sv
// Shares one storage controller port between the IFU and LSU requesters.
// One transaction is held in flight at a time, and a watchdog aborts hung accesses.
module storage_arbiter #(
  parameter int MEM_W          = 32,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ifu_req,
  input  logic [31:0]          ifu_addr,
  output logic                 ifu_gnt,
  output logic                 ifu_rvalid,
  output logic [MEM_W-1:0]     ifu_rdata,
  output logic                 ifu_err,
  input  logic                 lsu_req,
  input  logic                 lsu_we,
  input  logic [MEM_W/8-1:0]   lsu_be,
  input  logic [31:0]          lsu_addr,
  input  logic [MEM_W-1:0]     lsu_wdata,
  output logic                 lsu_gnt,
  output logic                 lsu_rvalid,
  output logic [MEM_W-1:0]     lsu_rdata,
  output logic                 lsu_err,
  output logic                 mem_access,
  output logic                 mem_is_writing,
  output logic [31:0]          mem_addr,
  output logic [MEM_W-1:0]     mem_wdata,
  output logic [MEM_W/8-1:0]   mem_be,
  input  logic [MEM_W-1:0]     mem_rdata,
  input  logic                 mem_valid
);

  localparam int BE_W  = MEM_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic               r_ownerLsu;
  logic               r_lastLsu;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [BE_W-1:0]    r_be;
  logic [MEM_W-1:0]   r_wdata;
  logic [CNT_W-1:0]   r_count;

  logic               w_lsuWins;
  logic               w_take;
  logic               w_ifuGnt;
  logic               w_lsuGnt;
  logic               w_cntMax;
  logic               w_done;
  logic               w_timeout;
  logic               w_finish;

  // r_lastLsu=0 means IFU was served last, so the LSU wins the next tie.
  always_comb begin
    w_lsuWins = 1'b0;
    if (lsu_req) begin
      if (!ifu_req)
        w_lsuWins = 1'b1;
      else if (ARB_MODE == 1)
        w_lsuWins = 1'b1;
      else
        w_lsuWins = !r_lastLsu;
    end
  end

  assign w_take    = rst && (r_state == IDLE) && (ifu_req || lsu_req);
  assign w_lsuGnt  = w_take && w_lsuWins;
  assign w_ifuGnt  = w_take && !w_lsuWins;

  assign w_cntMax  = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_done    = rst && (r_state == WAIT) && mem_valid;
  assign w_timeout = rst && (r_state == WAIT) && !mem_valid && w_cntMax;
  assign w_finish  = w_done || w_timeout;

  always_ff @(posedge clk) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_ifuGnt || w_lsuGnt) w_nextState = ISSUE;
      ISSUE:   w_nextState = WAIT;
      WAIT:    if (w_finish) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Latched request stays on the controller pins until the transaction ends.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ownerLsu <= 1'b0;
      r_lastLsu  <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
    end else if (w_ifuGnt || w_lsuGnt) begin
      r_ownerLsu <= w_lsuGnt;
      r_lastLsu  <= w_lsuGnt;
      r_we       <= w_lsuGnt && lsu_we;
      r_addr     <= w_lsuGnt ? lsu_addr : ifu_addr;
      r_be       <= w_lsuGnt ? lsu_be : {BE_W{1'b1}};
      r_wdata    <= w_lsuGnt ? lsu_wdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      r_count <= '0;
    else if ((r_state == WAIT) && !w_finish)
      r_count <= r_count + CNT_W'(1);
    else
      r_count <= '0;
  end

  always_comb begin
    ifu_gnt        = w_ifuGnt;
    lsu_gnt        = w_lsuGnt;
    mem_access     = rst && (r_state == ISSUE);
    mem_is_writing = r_we;
    mem_addr       = r_addr;
    mem_wdata      = r_wdata;
    mem_be         = r_be;
    ifu_rvalid     = w_finish && !r_ownerLsu;
    lsu_rvalid     = w_finish && r_ownerLsu;
    ifu_err        = w_timeout && !r_ownerLsu;
    lsu_err        = w_timeout && r_ownerLsu;
    ifu_rdata      = (w_done && !r_ownerLsu) ? mem_rdata : '0;
    lsu_rdata      = (w_done && r_ownerLsu) ? mem_rdata : '0;
  end

endmodule

// File: doc/storage_arbiter.md
Name: storage_arbiter

Overview:
- Shares the single storage controller port between the instruction-fetch requester (IFU) and the vector/scalar load-store requester (LSU).
- Arbitrates, then holds one outstanding transaction at a time, keeping address and data stable until the controller reports completion.
- Routes the response back to the owning requester.
- A watchdog aborts transactions that never complete, such as a hung external SPI fetch.

Parameters:
- MEM_W, 32: data bus width in bits; byte-enable width is MEM_W/8.
- ARB_MODE, 0: 0 = round-robin; 1 = fixed priority, LSU over IFU.
- TIMEOUT_CYCLES, 1024: number of WAIT cycles without mem_valid before abort. Must be ≥ 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- ifu_req  in  1  IFU read request; held until granted
- ifu_addr  in  32  IFU byte address
- ifu_gnt  out  1  IFU request accepted this cycle
- ifu_rvalid  out  1  IFU response valid, 1-cycle pulse
- ifu_rdata  out  MEM_W  IFU read data
- ifu_err  out  1  qualifies ifu_rvalid; 1 = timeout
- lsu_req  in  1  LSU request; held until granted
- lsu_we  in  1  1 = write
- lsu_be  in  MEM_W/8  LSU byte enables
- lsu_addr  in  32  LSU byte address
- lsu_wdata  in  MEM_W  LSU write data
- lsu_gnt  out  1  LSU request accepted this cycle
- lsu_rvalid  out  1  LSU response valid, 1-cycle pulse
- lsu_rdata  out  MEM_W  LSU read data
- lsu_err  out  1  qualifies lsu_rvalid; 1 = timeout
- mem_access  out  1  to controller memory_access
- mem_is_writing  out  1  to controller memory_is_writing
- mem_addr  out  32  to controller addr
- mem_wdata  out  MEM_W  to controller d_in
- mem_be  out  MEM_W/8  to controller mem_be
- mem_rdata  in  MEM_W  from controller d_out
- mem_valid  in  1  from controller out_valid

Behaviour:
- States: IDLE, ISSUE, WAIT.

Reset (rst=0 at a clock edge):
- State goes to IDLE.
- Every output is 0: gnt, rvalid, err, rdata, all mem_* signals.
- The round-robin pointer is set to "IFU last served", so LSU wins the first tie.
- Timeout counter is 0.
- Any in-flight transaction is dropped and no response is produced for it.

IDLE:
- gnt is combinational, asserted to the winner in the same cycle any req=1.
- On that edge the arbiter latches owner, addr, we, be, wdata and moves to ISSUE.
- IFU transactions are always reads: we=0, be=all ones.

Arbitration:
- Only one gnt may be high per cycle.
- ARB_MODE=1: LSU always wins a tie.
- ARB_MODE=0: the requester not served last wins a tie. The pointer updates on every grant.
- A lone requester always wins regardless of pointer.

ISSUE (exactly 1 cycle):
- mem_access=1, and mem_is_writing/addr/wdata/be driven from the latched values.
- Next state is WAIT.

WAIT:
- mem_access=0.
- mem_addr, mem_wdata, mem_be and mem_is_writing stay stable at the latched values, because the controller re-reads addr during external fetch.
- The counter increments each cycle.

Completion:
- On mem_valid=1 in WAIT, the owner's rvalid=1 in the same cycle (combinational).
- The owner's rdata=mem_rdata and err=0; state returns to IDLE and the counter clears.
- Writes complete the same way; rdata is don't-care.

Timeout:
- When the counter reaches TIMEOUT_CYCLES-1 without mem_valid, the owner gets rvalid=1, err=1, rdata=0, and state returns to IDLE.
- mem_valid arriving on that same cycle takes precedence as a normal completion.

Other rules:
- mem_valid outside WAIT is ignored.
- The non-owner's rvalid and err stay 0.
- rdata is 0 whenever rvalid=0.

Throughput and latency:
- At most one transaction is outstanding at a time.
- Minimum turnaround is grant → ISSUE → WAIT: 3 cycles when the response arrives in the first WAIT cycle.
- A new grant is possible in the IDLE cycle right after completion.

Test Plan:
- Single read: ifu_req with addr=0x0000_0100; controller returns mem_valid the first WAIT cycle with 0xDEADBEEF → ifu_gnt at T0, mem_access only at T1, ifu_rvalid=1 with rdata=0xDEADBEEF and err=0 at T2, lsu_rvalid=0 throughout.
- Write: lsu_we=1, be=4'b0011, addr=0x0000_0200, wdata=0x1234_5678 → mem_is_writing=1, mem_be=0011 and wdata stable from T1 until mem_valid; lsu_rvalid=1 on mem_valid.
- Contention, ARB_MODE=0, both reqs held for 4 transactions → grant order LSU, IFU, LSU, IFU. With ARB_MODE=1 → LSU, LSU, … until lsu_req drops.
- Stall: mem_valid delayed 50 cycles on addr=0x0001_0000 → mem_addr constant for all 50 WAIT cycles and no second gnt while busy.
- Timeout, TIMEOUT_CYCLES=8, mem_valid never asserts → owner rvalid=1, err=1, rdata=0 exactly 8 WAIT cycles after ISSUE; next request grants normally.
- Reset mid-WAIT → all outputs 0 next cycle; a late mem_valid is ignored and produces no rvalid; the first post-reset tie goes to LSU.
